// File: rtl/encoder_8b10b.sv
// rtl/encoder_8b10b.sv - 8b/10b encoder with running-disparity tracking, one symbol per clock
module encoder_8b10b #(
    parameter logic INIT_RD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    input  logic       k_in,
    input  logic       rd_load,
    input  logic       rd_load_val,
    output logic       valid_out,
    output logic [9:0] data_out,
    output logic       rd_out,
    output logic       k_err
);

    // Returns {RD- column, RD+ column} for the abcdei sub-block.
    function automatic logic [11:0] enc6(input logic [4:0] x);
        case (x)
            5'd0:    enc6 = {6'b100111, 6'b011000};
            5'd1:    enc6 = {6'b011101, 6'b100010};
            5'd2:    enc6 = {6'b101101, 6'b010010};
            5'd3:    enc6 = {6'b110001, 6'b110001};
            5'd4:    enc6 = {6'b110101, 6'b001010};
            5'd5:    enc6 = {6'b101001, 6'b101001};
            5'd6:    enc6 = {6'b011001, 6'b011001};
            5'd7:    enc6 = {6'b111000, 6'b000111};
            5'd8:    enc6 = {6'b111001, 6'b000110};
            5'd9:    enc6 = {6'b100101, 6'b100101};
            5'd10:   enc6 = {6'b010101, 6'b010101};
            5'd11:   enc6 = {6'b110100, 6'b110100};
            5'd12:   enc6 = {6'b001101, 6'b001101};
            5'd13:   enc6 = {6'b101100, 6'b101100};
            5'd14:   enc6 = {6'b011100, 6'b011100};
            5'd15:   enc6 = {6'b010111, 6'b101000};
            5'd16:   enc6 = {6'b011011, 6'b100100};
            5'd17:   enc6 = {6'b100011, 6'b100011};
            5'd18:   enc6 = {6'b010011, 6'b010011};
            5'd19:   enc6 = {6'b110010, 6'b110010};
            5'd20:   enc6 = {6'b001011, 6'b001011};
            5'd21:   enc6 = {6'b101010, 6'b101010};
            5'd22:   enc6 = {6'b011010, 6'b011010};
            5'd23:   enc6 = {6'b111010, 6'b000101};
            5'd24:   enc6 = {6'b110011, 6'b001100};
            5'd25:   enc6 = {6'b100110, 6'b100110};
            5'd26:   enc6 = {6'b010110, 6'b010110};
            5'd27:   enc6 = {6'b110110, 6'b001001};
            5'd28:   enc6 = {6'b001110, 6'b001110};
            5'd29:   enc6 = {6'b101110, 6'b010001};
            5'd30:   enc6 = {6'b011110, 6'b100001};
            default: enc6 = {6'b101011, 6'b010100};
        endcase
    endfunction

    // Data fghj sub-block (primary x.7), {RD- column, RD+ column}.
    function automatic logic [7:0] enc4_d(input logic [2:0] y);
        case (y)
            3'd0:    enc4_d = {4'b1011, 4'b0100};
            3'd1:    enc4_d = {4'b1001, 4'b1001};
            3'd2:    enc4_d = {4'b0101, 4'b0101};
            3'd3:    enc4_d = {4'b1100, 4'b0011};
            3'd4:    enc4_d = {4'b1101, 4'b0010};
            3'd5:    enc4_d = {4'b1010, 4'b1010};
            3'd6:    enc4_d = {4'b0110, 4'b0110};
            default: enc4_d = {4'b1110, 4'b0001};
        endcase
    endfunction

    // Control fghj sub-block, {RD- column, RD+ column}.
    function automatic logic [7:0] enc4_k(input logic [2:0] y);
        case (y)
            3'd0:    enc4_k = {4'b1011, 4'b0100};
            3'd1:    enc4_k = {4'b0110, 4'b1001};
            3'd2:    enc4_k = {4'b1010, 4'b0101};
            3'd3:    enc4_k = {4'b1100, 4'b0011};
            3'd4:    enc4_k = {4'b1101, 4'b0010};
            3'd5:    enc4_k = {4'b0101, 4'b1010};
            3'd6:    enc4_k = {4'b1001, 4'b0110};
            default: enc4_k = {4'b0111, 4'b1000};
        endcase
    endfunction

    logic       valid_q, valid_d;
    logic [9:0] data_q, data_d;
    logic       rd_q, rd_d;
    logic       k_err_q, k_err_d;

    logic       rd_start;
    logic       k_ok;
    logic       k_bad;
    logic [4:0] edcba;
    logic [2:0] hgf;
    logic [11:0] six_pair;
    logic [5:0] six;
    logic       rd_mid;
    logic       use_alt;
    logic [7:0] four_pair;
    logic [3:0] four;
    logic       rd_next;

    always_comb begin
        rd_start  = rd_load ? rd_load_val : rd_q;
        k_ok      = (data_in[4:0] == 5'd28) || (data_in == 8'hF7) || (data_in == 8'hFB)
                 || (data_in == 8'hFD) || (data_in == 8'hFE);
        k_bad     = k_in && !k_ok;
        // Unsupported control codes fall back to K28.5 (comma) so the link stays aligned.
        edcba     = k_bad ? 5'd28 : data_in[4:0];
        hgf       = k_bad ? 3'd5  : data_in[7:5];

        six_pair  = (k_in && edcba == 5'd28) ? {6'b001111, 6'b110000} : enc6(edcba);
        six       = rd_start ? six_pair[5:0] : six_pair[11:6];
        rd_mid    = rd_start ^ ($countones(six) != 3);

        use_alt   = rd_mid ? (edcba == 5'd11 || edcba == 5'd13 || edcba == 5'd14)
                           : (edcba == 5'd17 || edcba == 5'd18 || edcba == 5'd20);
        if (k_in)
            four_pair = enc4_k(hgf);
        else if (hgf == 3'd7 && use_alt)
            four_pair = {4'b0111, 4'b1000};
        else
            four_pair = enc4_d(hgf);
        four      = rd_mid ? four_pair[3:0] : four_pair[7:4];
        rd_next   = rd_mid ^ ($countones(four) != 2);

        valid_d   = valid_in;
        k_err_d   = valid_in && k_bad;
        data_d    = valid_in ? {six, four} : data_q;
        rd_d      = valid_in ? rd_next : rd_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 10'b0;
            rd_q    <= INIT_RD;
            k_err_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            k_err_q <= k_err_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign rd_out    = rd_q;
    assign k_err     = k_err_q;

endmodule
